// File: rtl/life_manager.sv
// life_manager
//   Owns the player's life count and drives the screen controller's life input.
//   It decrements the count on a drained ball and holds the ball frozen for a fixed
//   number of video frames after each loss. Bonus lives can be awarded, up to a ceiling.
//   When the screen controller drops start, the block returns to IDLE.
//
// Configuration macro: LIFE_MANAGER_BONUS_EN
//   defined   - bonusLife awards one life, saturating at MAX_LIVES
//   undefined - bonusLife is ignored; life only loads or decrements
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   start         in   game running (screen controller start output)
//   startOfFrame  in   one-cycle pulse per video frame
//   ballLost      in   one-cycle pulse, ball drained
//   bonusLife     in   one-cycle pulse, award one life
//   life          out  [3:0] current life count (registered)
//   ballFreeze    out  ball held at launch, physics stalled (registered)
//   lifeLostPulse out  one-cycle pulse on each lost ball (registered)
module life_manager #(
  parameter int unsigned INIT_LIVES     = 3,
  parameter int unsigned MAX_LIVES      = 9,
  parameter int unsigned RESPAWN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       startOfFrame,
  input  logic       ballLost,
  input  logic       bonusLife,
  output logic [3:0] life,
  output logic       ballFreeze,
  output logic       lifeLostPulse
);

  localparam int unsigned CntW = $clog2(RESPAWN_FRAMES + 1);

  localparam logic [3:0]      LifeInit = 4'(INIT_LIVES);
  localparam logic [3:0]      LifeMax  = 4'(MAX_LIVES);
  localparam logic [CntW-1:0] CntLast  = CntW'(RESPAWN_FRAMES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StRespawn,
    StOver
  } state_e;

  state_e          r_state;
  logic [3:0]      r_life;
  logic            r_freeze;
  logic            r_lost_pulse;
  logic [CntW-1:0] r_frame_cnt;

  logic            w_bonus;
  logic [3:0]      w_life_inc;

`ifdef LIFE_MANAGER_BONUS_EN
  assign w_bonus = bonusLife;
`else
  logic w_unused_bonus;
  assign w_unused_bonus = bonusLife;
  assign w_bonus        = 1'b0;
`endif

  // Saturating increment; at the ceiling the award is silently dropped.
  assign w_life_inc = (r_life < LifeMax) ? r_life + 4'd1 : r_life;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_life       <= LifeInit;
      r_freeze     <= 1'b1;
      r_lost_pulse <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_lost_pulse <= 1'b0;
      if (!start) begin
        // Leaving the game beats every other event.
        r_state     <= StIdle;
        r_life      <= LifeInit;
        r_freeze    <= 1'b1;
        r_frame_cnt <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_life   <= LifeInit;
            r_state  <= StPlay;
            r_freeze <= 1'b0;
          end
          StPlay: begin
            r_freeze <= 1'b0;
            if (ballLost) begin
              r_lost_pulse <= 1'b1;
              r_freeze     <= 1'b1;
              r_frame_cnt  <= '0;
              if (w_bonus) begin
                // Loss and award cancel out; never fatal.
                r_state <= StRespawn;
              end else if (r_life > 4'd1) begin
                r_life  <= r_life - 4'd1;
                r_state <= StRespawn;
              end else begin
                r_life  <= 4'd0;
                r_state <= StOver;
              end
            end else if (w_bonus) begin
              r_life <= w_life_inc;
            end
          end
          StRespawn: begin
            r_freeze <= 1'b1;
            if (w_bonus) begin
              r_life <= w_life_inc;
            end
            if (startOfFrame) begin
              if (r_frame_cnt == CntLast) begin
                r_frame_cnt <= '0;
                r_state     <= StPlay;
                r_freeze    <= 1'b0;
              end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
              end
            end
          end
          StOver: begin
            r_life   <= 4'd0;
            r_freeze <= 1'b1;
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  assign life          = r_life;
  assign ballFreeze    = r_freeze;
  assign lifeLostPulse = r_lost_pulse;

endmodule

// File: tb/tb_life_manager.sv
module tb_life_manager;

  logic       clk;
  logic       reset;
  logic       start;
  logic       startOfFrame;
  logic       ballLost;
  logic       bonusLife;
  logic [3:0] life;
  logic       ballFreeze;
  logic       lifeLostPulse;

  int n_cmp;
  int n_err;

  life_manager #(
    .INIT_LIVES    (3),
    .MAX_LIVES     (9),
    .RESPAWN_FRAMES(4)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .startOfFrame (startOfFrame),
    .ballLost     (ballLost),
    .bonusLife    (bonusLife),
    .life         (life),
    .ballFreeze   (ballFreeze),
    .lifeLostPulse(lifeLostPulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one active edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lose_ball();
    ballLost = 1'b1;
    tick();
    ballLost = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    start        = 1'b0;
    startOfFrame = 1'b0;
    ballLost     = 1'b0;
    bonusLife    = 1'b0;
    #12;
    // 1. Reset and start.
    check_eq("rst_life", int'(life), 3);
    check_eq("rst_freeze", int'(ballFreeze), 1);
    check_eq("rst_pulse", int'(lifeLostPulse), 0);
    reset = 1'b0;
    tick();
    check_eq("idle_freeze", int'(ballFreeze), 1);
    start = 1'b1;
    #1;
    check_eq("start_pre_edge_freeze", int'(ballFreeze), 1);
    tick();
    check_eq("play_freeze", int'(ballFreeze), 0);
    check_eq("play_life", int'(life), 3);

    // 2. First loss and respawn timing.
    lose_ball();
    check_eq("loss1_life", int'(life), 2);
    check_eq("loss1_pulse", int'(lifeLostPulse), 1);
    check_eq("loss1_freeze", int'(ballFreeze), 1);
    tick();
    check_eq("loss1_pulse_drop", int'(lifeLostPulse), 0);
    lose_ball();
    check_eq("respawn_ignore_loss_life", int'(life), 2);
    check_eq("respawn_ignore_loss_pulse", int'(lifeLostPulse), 0);
    for (int i = 0; i < 4; i++) begin
      startOfFrame = 1'b1;
      if (i == 1) ballLost = 1'b1;
      tick();
      startOfFrame = 1'b0;
      ballLost     = 1'b0;
      check_eq($sformatf("respawn_freeze_f%0d", i + 1), int'(ballFreeze), (i < 3) ? 1 : 0);
      check_eq($sformatf("respawn_life_f%0d", i + 1), int'(life), 2);
      tick();
    end

    // 3. Remaining losses down to game over.
    lose_ball();
    check_eq("loss2_life", int'(life), 1);
    frames(4);
    check_eq("loss2_unfreeze", int'(ballFreeze), 0);
    lose_ball();
    check_eq("loss3_life", int'(life), 0);
    check_eq("loss3_pulse", int'(lifeLostPulse), 1);
    check_eq("loss3_freeze", int'(ballFreeze), 1);
    tick();
    check_eq("over_pulse_drop", int'(lifeLostPulse), 0);
    bonusLife = 1'b1;
    tick();
    bonusLife = 1'b0;
    check_eq("over_bonus_life", int'(life), 0);
    lose_ball();
    check_eq("over_loss_life", int'(life), 0);
    check_eq("over_loss_pulse", int'(lifeLostPulse), 0);
    start = 1'b0;
    tick();
    check_eq("restart_life", int'(life), 3);
    check_eq("restart_freeze", int'(ballFreeze), 1);
    start = 1'b1;
    tick();
    check_eq("replay_freeze", int'(ballFreeze), 0);

`ifdef LIFE_MANAGER_BONUS_EN
    // 4. Bonus saturation, then simultaneous loss and bonus.
    for (int i = 0; i < 7; i++) begin
      bonusLife = 1'b1;
      tick();
      bonusLife = 1'b0;
      check_eq($sformatf("bonus_%0d_life", i + 1), int'(life), (3 + i + 1 > 9) ? 9 : 3 + i + 1);
    end
    ballLost  = 1'b1;
    bonusLife = 1'b1;
    tick();
    ballLost  = 1'b0;
    bonusLife = 1'b0;
    check_eq("loss_bonus_life", int'(life), 9);
    check_eq("loss_bonus_pulse", int'(lifeLostPulse), 1);
    check_eq("loss_bonus_freeze", int'(ballFreeze), 1);
    frames(4);
    check_eq("loss_bonus_unfreeze", int'(ballFreeze), 0);
`else
    // 5. Bonus disabled: awards ignored, combined event is a plain loss.
    for (int i = 0; i < 3; i++) begin
      bonusLife = 1'b1;
      tick();
      bonusLife = 1'b0;
      check_eq($sformatf("nobonus_%0d_life", i + 1), int'(life), 3);
    end
    ballLost  = 1'b1;
    bonusLife = 1'b1;
    tick();
    ballLost  = 1'b0;
    bonusLife = 1'b0;
    check_eq("nobonus_loss_life", int'(life), 2);
    check_eq("nobonus_loss_pulse", int'(lifeLostPulse), 1);
    frames(4);
    check_eq("nobonus_unfreeze", int'(ballFreeze), 0);
`endif

    // 6. Asynchronous reset in the middle of a respawn.
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    lose_ball();
    check_eq("mid_life", int'(life), 2);
    frames(2);
    check_eq("mid_freeze", int'(ballFreeze), 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_life", int'(life), 3);
    check_eq("async_rst_freeze", int'(ballFreeze), 1);
    check_eq("async_rst_pulse", int'(lifeLostPulse), 0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rel_freeze", int'(ballFreeze), 1);
    tick();
    check_eq("rel_play_freeze", int'(ballFreeze), 0);
    check_eq("rel_play_life", int'(life), 3);
    // Frame counter must have been cleared: a full four frames are needed again.
    lose_ball();
    frames(3);
    check_eq("cnt_clear_3", int'(ballFreeze), 1);
    frames(1);
    check_eq("cnt_clear_4", int'(ballFreeze), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
